// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one SPRITE_W x SPRITE_H indexed-colour sprite from a
// synchronous sprite ROM into the frame buffer at (pos_x, pos_y). It honours
// a transparent palette index and horizontal flip, and clips at the screen edges.
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   start                   draw request (only honoured when idle)
//   pos_x, pos_y            sprite top-left on screen, latched on accepted start
//   flip_h, trans_idx       mirror enable / transparent index, latched on start
//   busy, done              blit in progress / one-cycle completion pulse
//   rom_address, rom_q      sprite ROM read port (data one cycle after address)
//   fb_we, fb_addr, fb_data frame-buffer write request, held until fb_ready
//   fb_ready                frame buffer accepts the write this cycle
module sprite_blitter #(
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 32,
  parameter int unsigned FB_W     = 320,
  parameter int unsigned FB_H     = 240,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned FB_AW    = 17
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             flip_h,
  input  logic [IDX_W-1:0] trans_idx,
  output logic             busy,
  output logic             done,
  output logic [9:0]       rom_address,
  input  logic [IDX_W-1:0] rom_q,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [IDX_W-1:0] fb_data,
  input  logic             fb_ready
);

  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned SW = 11;  // screen-coordinate width, wide enough to never wrap

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             launch;   // start accepted, first fetch issued next cycle
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [9:0]       org_x;
  logic [9:0]       org_y;
  logic             flip;
  logic [IDX_W-1:0] tidx;

  // ROM address of sprite pixel (rr, cc), mirrored when flipping
  function automatic logic [9:0] rom_addr_of(input logic [RW-1:0] rr,
                                             input logic [CW-1:0] cc,
                                             input logic          fl);
    logic [CW-1:0] src_col;
    src_col = fl ? (CW'(SPRITE_W - 1) - cc) : cc;
    return (10'(rr) * 10'(SPRITE_W)) + 10'(src_col);
  endfunction

  // Next position in raster order
  logic          col_last;
  logic          last_px;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  assign col_last = (col == CW'(SPRITE_W - 1));
  assign last_px  = col_last && (row == RW'(SPRITE_H - 1));
  assign col_nxt  = col_last ? '0 : (col + CW'(1));
  assign row_nxt  = col_last ? (row + RW'(1)) : row;

  // Screen position of the current pixel and its clip / transparency verdict
  logic [SW-1:0]    scr_x;
  logic [SW-1:0]    scr_y;
  logic             skip_px;
  logic [FB_AW-1:0] scr_addr;

  assign scr_x    = SW'(org_x) + SW'(col);
  assign scr_y    = SW'(org_y) + SW'(row);
  assign skip_px  = (rom_q == tidx) || (scr_x >= SW'(FB_W)) || (scr_y >= SW'(FB_H));
  assign scr_addr = (FB_AW'(scr_y) * FB_AW'(FB_W)) + FB_AW'(scr_x);

  // Main controller; rom_address is loaded on entry to FETCH so that rom_q is
  // valid during WAIT
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      launch      <= 1'b0;
      row         <= '0;
      col         <= '0;
      org_x       <= '0;
      org_y       <= '0;
      flip        <= 1'b0;
      tidx        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fb_we       <= 1'b0;
      rom_address <= '0;
      fb_addr     <= '0;
      fb_data     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            launch      <= 1'b0;
            busy        <= 1'b1;
            rom_address <= rom_addr_of('0, '0, flip);
            state       <= FETCH;
          end else if (start) begin
            launch <= 1'b1;
            org_x  <= pos_x;
            org_y  <= pos_y;
            flip   <= flip_h;
            tidx   <= trans_idx;
            row    <= '0;
            col    <= '0;
          end
        end

        FETCH: state <= WAIT;

        WAIT: begin
          if (!skip_px) begin
            fb_we   <= 1'b1;
            fb_addr <= scr_addr;
            fb_data <= rom_q;
            state   <= WRITE;
          end else if (last_px) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row         <= row_nxt;
            col         <= col_nxt;
            rom_address <= rom_addr_of(row_nxt, col_nxt, flip);
            state       <= FETCH;
          end
        end

        WRITE: begin
          if (fb_ready) begin
            fb_we <= 1'b0;
            if (last_px) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row         <= row_nxt;
              col         <= col_nxt;
              rom_address <= rom_addr_of(row_nxt, col_nxt, flip);
              state       <= FETCH;
            end
          end
        end

        DONE: state <= IDLE;

        default: begin
          busy  <= 1'b0;
          fb_we <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies one 32x32 indexed-colour sprite from its synchronous sprite ROM into the on-chip frame buffer at a requested screen position. It is the write side of the sprite path: the per-sprite display logic reads ROM/palette data by pixel coordinate, and this block instead walks the ROM linearly and writes palette indices into frame-buffer memory. It supports transparency, horizontal flip and screen-edge clipping. It sits between the game-logic FSM, which issues draw commands, and the frame-buffer write port.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- IDX_W, 3, palette index width
- FB_AW, 17, frame-buffer address width

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  draw request, sampled only in IDLE
- pos_x  in  10  screen X of sprite top-left, latched on accepted start
- pos_y  in  10  screen Y of sprite top-left, latched on accepted start
- flip_h  in  1  mirror horizontally, latched on accepted start
- trans_idx  in  IDX_W  palette index treated as transparent, latched on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the blit completes
- rom_address  out  10  sprite ROM address, row*SPRITE_W + col
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- fb_we  out  1  frame-buffer write request
- fb_addr  out  FB_AW  write address, y*FB_W + x
- fb_data  out  IDX_W  palette index to write
- fb_ready  in  1  frame buffer accepts the write this cycle

## Operation
- States: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE: start=1 latches pos_x, pos_y, flip_h and trans_idx. It clears the row and column counters (r=0, c=0) and moves to FETCH. start is ignored in every other state.
- FETCH: rom_address = r*SPRITE_W + (flip_h ? SPRITE_W-1-c : c); go to WAIT.
- WAIT: rom_q becomes valid at the end of this cycle. Compute sx = pos_x + c and sy = pos_y + r at 11-bit width (no wrap).
  - If rom_q == trans_idx, or sx >= FB_W, or sy >= FB_H, the pixel is skipped: advance the counters and go to FETCH, or to DONE after the last pixel.
  - Otherwise register fb_addr = sy*FB_W + sx and fb_data = rom_q, and go to WRITE.
- WRITE: fb_we=1 with fb_addr and fb_data held stable until fb_ready=1.
  - A write completes on a cycle where fb_we=1 and fb_ready=1.
  - That same cycle, advance the counters and go to FETCH, or to DONE after the last pixel.
- Counter advance: c increments; at c=SPRITE_W-1, c wraps to 0 and r increments. The last pixel is r=SPRITE_H-1, c=SPRITE_W-1.
- DONE: done=1 for one cycle, then IDLE. busy is low in DONE and IDLE.
- Reset at any state: next cycle is IDLE, with busy=0, done=0, fb_we=0, rom_address=0, fb_addr=0 and fb_data=0. A partial blit is abandoned; writes already accepted stand.

## Timing
- Reset values: all outputs 0.
- start accepted at edge N: busy=1 and the FETCH address appear after edge N+1.
- Opaque pixel: FETCH, WAIT, WRITE = 3 cycles minimum, plus 1 cycle for each cycle fb_ready is low.
- Skipped pixel: 2 cycles.
- Full opaque sprite with fb_ready held high: 1024*3 = 3072 cycles from FETCH of pixel 0 to DONE. done asserts 3073 cycles after the accepted-start edge.
- fb_we never asserts outside WRITE.
- fb_addr and fb_data change only on entry to WRITE.
- rom_address is stable through WAIT.

## Test plan
- Reset mid-WRITE with fb_ready=0: next cycle fb_we=0, busy=0, state IDLE; a following start at (0,0) runs normally.
- Opaque blit, pos=(10,20), flip_h=0, fb_ready=1, ROM pattern idx=(addr%7)+1, trans_idx=0:
  - exactly 1024 writes
  - first write fb_addr=20*320+10=6410
  - last write fb_addr=51*320+41=16361
  - done pulses once, exactly 3073 cycles after the start edge
- Transparency: ROM all 0 except addr 33 = 5, trans_idx=0, pos=(0,0): exactly one write, fb_addr=321, fb_data=5.
- Flip: flip_h=1, ROM addr 0 = 4, other entries transparent, pos=(0,0): single write at fb_addr=31, data 4.
- Clipping: pos=(300,230), all opaque: 20*10=200 writes, all with x<320 and y<240; done still pulses.
- Backpressure and ignored start:
  - fb_ready toggled pseudo-randomly; start pulsed while busy
  - fb_addr and fb_data are held while fb_we=1 and fb_ready=0
  - no write is lost or duplicated
  - the second start is ignored, giving exactly one done
